mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 38 +++
 rtl/mem_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - request, RAM and completion bundle for mem_ctrl
interface mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  rdy_in;
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_flush;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rw;
    logic [1:0]            mem_len;
    logic [31:0]           mem_wdata;
    logic [7:0]            mem_din;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic [7:0]            mem_dout;
    logic                  mem_wr;
    logic                  if_done;
    logic [31:0]           if_inst;
    logic                  mem_done;
    logic [31:0]           mem_rdata;
    logic                  if_stall_out;
    logic                  mem_stall_out;

    modport slave (
        input  rdy_in, if_req, if_addr, if_flush, mem_req, mem_addr, mem_rw,
               mem_len, mem_wdata, mem_din,
        output mem_a, mem_dout, mem_wr, if_done, if_inst, mem_done, mem_rdata,
               if_stall_out, mem_stall_out
    );

    modport master (
        output rdy_in, if_req, if_addr, if_flush, mem_req, mem_addr, mem_rw,
               mem_len, mem_wdata, mem_din,
        input  mem_a, mem_dout, mem_wr, if_done, if_inst, mem_done, mem_rdata,
               if_stall_out, mem_stall_out
    );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM arbiter for instruction fetch and load/store
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q;
    logic [2:0]            len_q;
    logic                  rw_q;
    logic                  is_if_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rbuf_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic [7:0]            mem_dout_q;
    logic [31:0]           if_inst_q;
    logic [31:0]           mem_rdata_q;

    logic       accept_mem, accept_if, busy;
    logic       last_rd, last_wr;
    logic       if_done_c, mem_done_c;
    logic [2:0] req_len;
    logic [2:0] cnt_next;
    logic [1:0] cap_idx;

    always_comb begin
        case (bus.mem_len)
            2'b00:   req_len = 3'd1;
            2'b01:   req_len = 3'd2;
            default: req_len = 3'd4;
        endcase
    end

    assign accept_mem = (state_q == IDLE) && bus.rdy_in && bus.mem_req;
    assign accept_if  = (state_q == IDLE) && bus.rdy_in && !bus.mem_req
                        && bus.if_req && !bus.if_flush;
    assign busy       = (state_q == BUSY_IF) || (state_q == BUSY_MEM);
    // Reads need one extra cycle because RAM data trails its address by a cycle.
    assign last_rd    = (cnt_q == len_q);
    assign last_wr    = (cnt_q == len_q - 3'd1);
    assign cnt_next   = cnt_q + 3'd1;
    assign cap_idx    = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d = state_q;
        if (bus.rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (accept_mem)
                        state_d = BUSY_MEM;
                    else if (accept_if)
                        state_d = BUSY_IF;
                end
                BUSY_IF: begin
                    if (bus.if_flush)
                        state_d = IDLE;
                    else if (last_rd)
                        state_d = DONE;
                end
                BUSY_MEM: begin
                    if (rw_q ? last_wr : last_rd)
                        state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign if_done_c  = (state_q == DONE) && is_if_q && bus.rdy_in && !bus.if_flush;
    assign mem_done_c = (state_q == DONE) && !is_if_q && bus.rdy_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            rw_q        <= 1'b0;
            is_if_q     <= 1'b0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else if (bus.rdy_in) begin
            state_q <= state_d;
            if (accept_mem || accept_if) begin
                mem_a_q <= accept_mem ? bus.mem_addr : bus.if_addr;
                len_q   <= accept_mem ? req_len : 3'd4;
                rw_q    <= accept_mem && bus.mem_rw;
                is_if_q <= !accept_mem;
                cnt_q   <= '0;
                rbuf_q  <= '0;
                if (accept_mem) begin
                    wdata_q    <= bus.mem_wdata;
                    mem_dout_q <= bus.mem_wdata[7:0];
                end
            end else if (busy) begin
                cnt_q <= cnt_next;
                if (cnt_next < len_q)
                    mem_a_q <= mem_a_q + ADDR_WIDTH'(1);
                mem_dout_q <= wdata_q[15:8];
                wdata_q    <= wdata_q >> 8;
                if (!rw_q && (cnt_q != 3'd0))
                    rbuf_q[{cap_idx, 3'b000} +: 8] <= bus.mem_din;
            end
            if (if_done_c)
                if_inst_q <= rbuf_q;
            if (mem_done_c && !rw_q)
                mem_rdata_q <= rbuf_q;
        end
    end

    // Completed data is shown during the done pulse itself, then kept until the next completion.
    assign bus.if_inst       = if_done_c ? rbuf_q : if_inst_q;
    assign bus.mem_rdata     = (mem_done_c && !rw_q) ? rbuf_q : mem_rdata_q;
    assign bus.if_done       = if_done_c;
    assign bus.mem_done      = mem_done_c;
    assign bus.mem_a         = mem_a_q;
    assign bus.mem_dout      = mem_dout_q;
    assign bus.mem_wr        = (state_q == BUSY_MEM) && rw_q && bus.rdy_in;
    assign bus.if_stall_out  = bus.if_req && !if_done_c;
    assign bus.mem_stall_out = bus.mem_req && !mem_done_c;

endmodule
